riscv_mc_ctrl: RTL

Multi-cycle RISC-V control unit: the successor to our single-cycle opcode decoder. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port, and supports R, I, LOAD, STORE, BRANCH, JAL and LUI. It also provides a memory-ready handshake, an optional illegal-opcode trap and a retired-instruction counter. It sits between the instruction register (IR) and the multi-cycle datapath (PC, IR, ALUOut, MDR and their muxes).

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/riscv_ctrl_decode.sv | 23 ++
 rtl/riscv_mc_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, FSM states, instruction classes and datapath mux encodings
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;
  typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_ILL} iclass_e;
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic PC_ALU    = 1'b0;
  localparam logic PC_ALUOUT = 1'b1;
  localparam logic WB_ALUOUT = 1'b0;
  localparam logic WB_MDR    = 1'b1;
endpackage

// File: rtl/riscv_ctrl_decode.sv
// riscv_ctrl_decode: maps a 7-bit opcode to its instruction class and a legal bit
module riscv_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_e    cls,
  output logic       legal
);
  always_comb begin
    cls = C_ILL;
    case (opcode)
      OP_R:      cls = C_R;
      OP_I:      cls = C_I;
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      OP_BRANCH: cls = C_BRANCH;
      OP_JAL:    cls = C_JAL;
      OP_LUI:    cls = C_LUI;
      default:   cls = C_ILL;
    endcase
    legal = cls != C_ILL;
  end
endmodule

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RISC-V control FSM with memory handshake, trap and retire counter
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit TRAP_EN     = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             mem2reg,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  iclass_e          cls;
  logic             legal, rdy, retire;

  riscv_ctrl_decode u_dec (.opcode(opcode), .cls(cls), .legal(legal));

  assign rdy     = mem_ready | ~MEM_WAIT_EN;
  assign state   = state_q;
  assign instret = instret_q;
  assign illegal = state_q == S_TRAP;

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RS2;
    alu_op    = ALU_ADD;
    pc_src    = PC_ALU;
    mem2reg   = WB_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_EXEC: begin
        case (cls)
          C_R: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_FUNCT;
          end
          C_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
          end
          C_LOAD, C_STORE: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
          end
          C_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_SUB;
            pc_write  = branch_taken;
            pc_src    = PC_ALUOUT;
          end
          C_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            pc_src    = PC_ALUOUT;
          end
          C_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = cls == C_LOAD;
        mem_write = cls == C_STORE;
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = cls == C_LOAD ? WB_MDR : WB_ALUOUT;
      end
      default: ;
    endcase
    if (rst) {pc_write, ir_write, reg_write, mem_read, mem_write} = 5'b0;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = legal ? S_EXEC : (TRAP_EN ? S_TRAP : S_FETCH);
        retire  = !legal && !TRAP_EN;
      end
      S_EXEC: begin
        state_d = cls == C_BRANCH ? S_FETCH :
                  (cls == C_LOAD || cls == C_STORE) ? S_MEM :
                  cls == C_ILL ? S_FETCH : S_WB;
        retire  = cls == C_BRANCH;
      end
      S_MEM: begin
        state_d = !rdy ? S_MEM : (cls == C_LOAD ? S_WB : S_FETCH);
        retire  = rdy && cls != C_LOAD;
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end
endmodule
